// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop. The operands are
// consumed LSB first, one bit per clock. A start/busy/done handshake launches
// an addition and reports its registered result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, res_r, res_nxt;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  // One full-adder slice, built from two half-adder stages.
  logic h1_s, h1_c, h2_c, s, c_nxt;
  assign h1_s  = a_r[0] ^ b_r[0];
  assign h1_c  = a_r[0] & b_r[0];
  assign s     = h1_s ^ c_r;
  assign h2_c  = h1_s & c_r;
  assign c_nxt = h1_c | h2_c;

  // New sum bits enter at the MSB. After WIDTH shifts the LSB has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = s;
    end else begin : g_resn
      assign res_nxt = {s, res_r[WIDTH-1:1]};
    end
  endgenerate

  // A new operation can start only from IDLE or from the single DONE cycle.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == ADD) && (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands, then shift one bit per cycle. The result
  // becomes visible only at completion. Busy and done are registered from
  // the next state, so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      c_r   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_nxt == ADD);
      done <= (state_nxt == DONE);
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        c_r   <= cin;
        cnt   <= '0;
        res_r <= '0;
      end else if (state == ADD) begin
        a_r   <= a_r >> 1;
        b_r   <= b_r >> 1;
        res_r <= res_nxt;
        c_r   <= c_nxt;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= res_nxt;
          cout <= c_nxt;
        end
      end
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder: the sequential successor of the team's single-bit combinational adder cells. It adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, using one full-adder slice (two half-adder stages) and a carry register. A start/busy/done handshake lets a controller launch an addition and collect the registered result. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  launch request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/cout are updated
sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH
cout  output  1  registered carry-out of the MSB

Behaviour:
- Interface: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal operand registers, shift register, bit counter and carry register all cleared.
  - Reset overrides start and any in-flight operation; a partial result is discarded and never reaches sum.
- FSM states: IDLE, ADD, DONE.
  - IDLE: if start=1, capture a, b and cin, clear the counter, go to ADD. Otherwise stay in IDLE.
  - ADD, every edge:
    - s = a_r[0] ^ b_r[0] ^ c_r.
    - c_next = (a_r[0]&b_r[0]) | (c_r&(a_r[0]^b_r[0])).
    - Shift a_r and b_r right by 1.
    - Shift s into the MSB of the internal result register.
    - c_r = c_next; counter += 1.
    - On the edge where the counter reaches WIDTH: copy the internal result to sum, set cout=c_next, go to DONE.
  - DONE (lasts exactly one cycle): if start=1, accept new operands as in IDLE and go to ADD. Otherwise go to IDLE.
- Outputs:
  - busy=1 exactly while in ADD, registered.
  - done=1 exactly while in DONE, registered.
- Latency: start is accepted at edge E0. busy is high from E0 to E_WIDTH. sum, cout and done update at E_WIDTH; done falls at E_WIDTH+1. Issue interval is WIDTH+1 cycles.
- sum and cout hold their last value until the next completion or reset. They do not change during ADD.
- start while busy=1 is ignored. No queuing, no error flag.
- Operand inputs a, b and cin may change freely after the accepting edge.
- Counter width is $clog2(WIDTH+1). With WIDTH=1 the block completes after one ADD cycle.
- Overflow wraps modulo 2^WIDTH; the lost bit appears on cout.

Test Plan:
- WIDTH=8; reset, then start with a=8'h5A, b=8'h3C, cin=0 -> done pulses for one cycle exactly 8 edges after the accepting edge; sum=8'h96, cout=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Previous sum is held unchanged throughout the second operation until its done edge.
- Start a=8'h10, b=8'h20; assert start again with a=8'hAA at cycle 3 of ADD -> ignored; result is sum=8'h30. Hold start=1 through the DONE cycle -> new operation accepted with no IDLE cycle; busy is re-asserted on the following edge.
- Start a=8'h77, b=8'h11; drive rst_n=0 at ADD cycle 4 for one edge -> busy=0, done=0, sum=0, cout=0 on that edge. No done pulse follows; the next start computes correctly.
- Randomised: 500 operations with random a, b, cin and random start gaps, at WIDTH=1, 8 and 16 -> {cout,sum} == a+b+cin on every done, and exactly one done per accepted start.
